// File: rtl/bicubic_simd_pkg.sv
// bicubic_simd_pkg: shared int12 lane types and limits for the SIMD datapaths.
package bicubic_simd_pkg;
    typedef logic signed [11:0] int12_t;
    typedef int12_t [3:0] int12x4_t;
    localparam int12_t INT12_MAX = 12'sh7FF;
    localparam int12_t INT12_MIN = 12'sh800;
endpackage

// File: rtl/dsp_simd4x_int12_sub_stream_if.sv
// dsp_simd4x_int12_sub_stream_if: input lane set and result stream handshakes.
interface dsp_simd4x_int12_sub_stream_if;
    import bicubic_simd_pkg::*;
    logic s_valid, s_ready, m_valid, m_ready;
    int12_t a0, a1, a2, a3, b0, b1, b2, b3;
    int12_t diff0, diff1, diff2, diff3;
    logic [3:0] ovf;
    modport master (
        output s_valid, a0, a1, a2, a3, b0, b1, b2, b3, m_ready,
        input  s_ready, m_valid, diff0, diff1, diff2, diff3, ovf
    );
    modport slave (
        input  s_valid, a0, a1, a2, a3, b0, b1, b2, b3, m_ready,
        output s_ready, m_valid, diff0, diff1, diff2, diff3, ovf
    );
endinterface

// File: rtl/dsp_simd_valid_pipe.sv
// dsp_simd_valid_pipe: valid-bit shift chain with one global advance; flush beats accept/advance.
module dsp_simd_valid_pipe #(
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   flush,
    input  logic                   s_valid,
    input  logic                   m_ready,
    output logic                   adv,
    output logic [PIPE_STAGES-2:0] stage_vld,
    output logic                   m_valid
);
    logic [PIPE_STAGES-1:0] r_vld;
    assign m_valid   = r_vld[PIPE_STAGES-1];
    assign stage_vld = r_vld[PIPE_STAGES-2:0];
    assign adv       = !m_valid || m_ready;
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn)
            r_vld <= '0;
        else if (flush)
            r_vld <= '0;
        else if (adv)
            r_vld <= {r_vld[PIPE_STAGES-2:0], s_valid};
endmodule

// File: rtl/dsp_simd4x_int12_sub_stream.sv
// dsp_simd4x_int12_sub_stream: 4-lane int12 subtract (a-b) in a PIPE_STAGES-deep stream pipeline.
// Define SIMD_SUB_SATURATE_EN to clamp overflowing lanes; otherwise results wrap mod 4096.
module dsp_simd4x_int12_sub_stream
    import bicubic_simd_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          flush,
    dsp_simd4x_int12_sub_stream_if.slave  s
);
    logic                          w_adv, w_m_valid;
    logic [PIPE_STAGES-2:0]        w_vld;
    int12x4_t                      w_a, w_b, w_res;
    logic [3:0][12:0]              w_e;
    logic [3:0]                    w_ovf;
    int12x4_t [PIPE_STAGES-1:0]    r_d;
    logic [PIPE_STAGES-1:0][3:0]   r_o;

    dsp_simd_valid_pipe #(.PIPE_STAGES(PIPE_STAGES)) u_vpipe (
        .clk       (clk),
        .aresetn   (aresetn),
        .flush     (flush),
        .s_valid   (s.s_valid),
        .m_ready   (s.m_ready),
        .adv       (w_adv),
        .stage_vld (w_vld),
        .m_valid   (w_m_valid)
    );

    assign w_a = {s.a3, s.a2, s.a1, s.a0};
    assign w_b = {s.b3, s.b2, s.b1, s.b0};

    // 13-bit exact difference per lane; overflow when the top two bits disagree
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_e[k]   = {w_a[k][11], w_a[k]} - {w_b[k][11], w_b[k]};
            w_ovf[k] = w_e[k][12] ^ w_e[k][11];
`ifdef SIMD_SUB_SATURATE_EN
            w_res[k] = w_ovf[k] ? (w_e[k][12] ? INT12_MIN : INT12_MAX) : w_e[k][11:0];
`else
            w_res[k] = w_e[k][11:0];
`endif
        end
    end

    // data stages load only behind a valid bit, so bubbles leave them untouched
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            r_d <= '0;
            r_o <= '0;
        end else begin
            if (w_adv && s.s_valid) begin
                r_d[0] <= w_res;
                r_o[0] <= w_ovf;
            end
            for (int k = 1; k < PIPE_STAGES; k++)
                if (w_adv && w_vld[k-1]) begin
                    r_d[k] <= r_d[k-1];
                    r_o[k] <= r_o[k-1];
                end
        end

    assign s.s_ready = w_adv;
    assign s.m_valid = w_m_valid;
    assign s.diff0   = r_d[PIPE_STAGES-1][0];
    assign s.diff1   = r_d[PIPE_STAGES-1][1];
    assign s.diff2   = r_d[PIPE_STAGES-1][2];
    assign s.diff3   = r_d[PIPE_STAGES-1][3];
    assign s.ovf     = r_o[PIPE_STAGES-1];
endmodule

// File: tb/tb_dsp_simd4x_int12_sub_stream.sv
// tb_dsp_simd4x_int12_sub_stream: directed checks of latency, overflow, backpressure, flush and reset.
module tb_dsp_simd4x_int12_sub_stream;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic flush = 1'b0;
    int   tests = 0;
    int   fails = 0;
    integer idx, rcv;
    logic took;

    dsp_simd4x_int12_sub_stream_if sif();

    dsp_simd4x_int12_sub_stream #(.PIPE_STAGES(2)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .flush   (flush),
        .s       (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input integer obs, input integer exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input integer d0, input integer d1,
                           input integer d2, input integer d3, input integer o);
        chk({tag, "_d0"}, sif.diff0, d0);
        chk({tag, "_d1"}, sif.diff1, d1);
        chk({tag, "_d2"}, sif.diff2, d2);
        chk({tag, "_d3"}, sif.diff3, d3);
        chk({tag, "_ovf"}, sif.ovf, o);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input integer a0, input integer a1, input integer a2, input integer a3,
                         input integer b0, input integer b1, input integer b2, input integer b3);
        sif.a0 = 12'(a0); sif.a1 = 12'(a1); sif.a2 = 12'(a2); sif.a3 = 12'(a3);
        sif.b0 = 12'(b0); sif.b1 = 12'(b1); sif.b2 = 12'(b2); sif.b3 = 12'(b3);
        sif.s_valid = 1'b1;
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sif.s_valid = 1'b0;
        #2;
        chk("rst_mvalid", sif.m_valid, 0);
        chk_out("rst", 0, 0, 0, 0, 0);
        tick;
        tick;
        aresetn = 1'b1;
        #1;
        chk("rst_rel_sready", sif.s_ready, 1);
        tick;
        chk("rst_rel_mvalid", sif.m_valid, 0);

        // basic latency
        sif.m_ready = 1'b1;
        drive(5, -3, 100, 0, 2, 4, -100, 0);
        tick;
        sif.s_valid = 1'b0;
        chk("lat_mvalid_1", sif.m_valid, 0);
        tick;
        chk("lat_mvalid_2", sif.m_valid, 1);
        chk_out("lat", 3, -7, 200, 0, 0);
        tick;
        chk("lat_drain", sif.m_valid, 0);

        // overflow and in-range extremes
        drive(2047, -2048, -2048, -1, -1, 1, 0, 2047);
        tick;
        sif.s_valid = 1'b0;
        tick;
        chk("ovf_mvalid", sif.m_valid, 1);
`ifdef SIMD_SUB_SATURATE_EN
        chk_out("ovf", 2047, -2048, -2048, -2048, 3);
`else
        chk_out("ovf", -2048, 2047, -2048, -2048, 3);
`endif
        tick;

        // backpressure: m_ready low for cycles 3..7
        idx = 0;
        rcv = 0;
        for (int c = 0; c < 14; c++) begin
            sif.m_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
            if (idx < 6) drive(100 * idx, -50 * idx, idx, 2047 - idx, idx, 50 * idx, -idx, -idx);
            else sif.s_valid = 1'b0;
            #1;
            chk("bp_sready", sif.s_ready, (c >= 3 && c <= 7) ? 0 : 1);
            if (c >= 3 && c <= 7) begin
                chk("bp_hold_mvalid", sif.m_valid, 1);
                chk_out("bp_hold", 99, -100, 2, 2047, 0);
            end
            if (sif.m_valid && sif.m_ready) begin
                chk_out("bp_out", 99 * rcv, -100 * rcv, 2 * rcv, 2047, 0);
                rcv++;
            end
            took = sif.s_valid && sif.s_ready;
            tick;
            if (took) idx++;
        end
        chk("bp_accepted", idx, 6);
        chk("bp_delivered", rcv, 6);
        chk("bp_empty", sif.m_valid, 0);

        // flush with two results in flight and a same-cycle input
        sif.m_ready = 1'b1;
        drive(1, 1, 1, 1, 0, 0, 0, 0);
        tick;
        drive(2, 2, 2, 2, 0, 0, 0, 0);
        tick;
        flush = 1'b1;
        sif.m_ready = 1'b0;
        drive(3, 3, 3, 3, 0, 0, 0, 0);
        #1;
        chk("fl_pre_mvalid", sif.m_valid, 1);
        tick;
        flush = 1'b0;
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("fl_mvalid", sif.m_valid, 0);
            tick;
        end

        // flush beats accept and advance while the output stage is empty
        drive(4, 4, 4, 4, 0, 0, 0, 0);
        tick;
        flush = 1'b1;
        drive(5, 5, 5, 5, 0, 0, 0, 0);
        #1;
        chk("fl2_sready", sif.s_ready, 1);
        tick;
        flush = 1'b0;
        sif.s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fl2_mvalid", sif.m_valid, 0);
            tick;
        end

        // mid-stream asynchronous reset
        drive(2047, 7, 7, 7, -1, 0, 0, 0);
        tick;
        drive(8, 8, 8, 8, 0, 0, 0, 0);
        tick;
        chk("mr_pre_mvalid", sif.m_valid, 1);
        chk("mr_pre_d1", sif.diff1, 7);
        chk("mr_pre_ovf", sif.ovf, 1);
        aresetn = 1'b0;
        #1;
        chk("mr_mvalid", sif.m_valid, 0);
        chk_out("mr", 0, 0, 0, 0, 0);
        tick;
        tick;
        sif.s_valid = 1'b0;
        aresetn = 1'b1;
        #1;
        chk("mr_rel_sready", sif.s_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("mr_rel_mvalid", sif.m_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsp_simd4x_int12_sub_stream.md
DSP_SIMD4X_INT12_SUB_STREAM -- requirements
Module: dsp_simd4x_int12_sub_stream

Interface
REQ-001 SHALL have parameter PIPE_STAGES, default 2, meaning the number of register stages from input acceptance to output; the legal range is 2..4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port flush, input, 1 bit: synchronous flush of all in-flight data.
REQ-005 SHALL have port s_valid, input, 1 bit: the input lane set is valid.
REQ-006 SHALL have port s_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 SHALL have ports a0..a3, input, 12 bits each, signed: minuend lanes.
REQ-008 SHALL have ports b0..b3, input, 12 bits each, signed: subtrahend lanes.
REQ-009 SHALL have port m_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port m_ready, input, 1 bit: the downstream accepts the result.
REQ-011 SHALL have ports diff0..diff3, output, 12 bits each, signed: lane results ai - bi.
REQ-012 SHALL have port ovf, output, 4 bits: per-lane overflow flag, aligned with diff.

Function
REQ-013 SHALL compute diffN = aN - bN independently per lane; no carry propagates between lanes.
REQ-014 SHALL transfer input on s_valid && s_ready, and output on m_valid && m_ready.
REQ-015 SHALL use one global advance signal: adv = !m_valid || m_ready; s_ready = adv.
REQ-016 SHALL shift every stage, including its valid bit, only when adv=1; stages hold when adv=0.
REQ-017 SHALL give a latency of exactly PIPE_STAGES cycles from acceptance to m_valid when m_ready stays 1.
REQ-018 SHALL sustain one transfer per cycle when s_valid=m_ready=1 continuously.
REQ-019 SHALL hold diff, ovf and m_valid stable while m_valid=1 and m_ready=0.
REQ-020 SHALL enter bubbles (s_valid=0) as valid=0 stages; bubbles are not collapsed.
REQ-021 SHALL set ovf[N] when the exact 13-bit result of aN - bN lies outside [-2048, 2047].
REQ-022 SHALL, when flush=1, clear all stage valid bits and m_valid on the next edge, ignoring any same-cycle input; data registers need not clear.
REQ-023 SHALL give flush priority over both accept and advance when they occur in the same cycle.
REQ-024 SHALL keep diff and ovf don't-care while m_valid=0; the bench checks them only on transfer.

Reset
REQ-025 SHALL, while aresetn=0, asynchronously force all valid bits, m_valid, diff0..3 and ovf to 0.
REQ-026 SHALL drive s_ready=1 in the first cycle after reset release.
REQ-027 SHALL discard all in-flight data on a reset asserted mid-stream; no result emerges after release.

Configuration
REQ-028 SHALL use the macro SIMD_SUB_SATURATE_EN to select overflow handling.
REQ-029 SHALL, with SIMD_SUB_SATURATE_EN defined, clamp overflowing lanes to 2047 (positive) or -2048 (negative).
REQ-030 SHALL, without SIMD_SUB_SATURATE_EN, wrap results modulo 4096; ovf behaves identically in both builds.

Structure
REQ-031 SHALL take the int12 lane type, the 4-lane packed vector type, and the INT12_MAX/INT12_MIN constants from the shared package bicubic_simd_pkg.
REQ-032 SHALL place the valid/advance pipeline control in one sub-module, dsp_simd_valid_pipe (parameter PIPE_STAGES; ports clk, aresetn, flush, s_valid, m_ready; outputs adv, stage valids, m_valid).

Verification
REQ-033 SHALL cover basic latency: a=(5,-3,100,0), b=(2,4,-100,0), m_ready=1 -> diff=(3,-7,200,0), ovf=0000, exactly PIPE_STAGES cycles after acceptance.
REQ-034 SHALL cover overflow: a0=2047, b0=-1; a1=-2048, b1=1 -> ovf=0011; diff0/diff1 = 2047/-2048 with SIMD_SUB_SATURATE_EN, and -2048/2047 without it.
REQ-035 SHALL cover backpressure: 6 back-to-back inputs with m_ready=0 for cycles 3..7 -> s_ready=0 while stalled, output held stable, all 6 results delivered in order with no loss or duplication.
REQ-036 SHALL cover flush: flush=1 with 2 results in flight and s_valid=1 in the same cycle -> m_valid=0 for the next PIPE_STAGES cycles and no result emerges.
REQ-037 SHALL cover mid-stream reset: aresetn pulsed low mid-stream -> all outputs 0 immediately, and s_ready=1 in the first cycle after release.
